// File: rtl/rsp_encoder.sv
// rsp_encoder: round-robin, store-and-forward framer that turns channel messages into
// PREFIX/ADDR/SRC/LEN/DATA/CRC byte frames. Define RSP_ENC_TIMEOUT_EN to close stalled messages.
module rsp_encoder #(
  parameter int N_CH    = 5,
  parameter int MAX_LEN = 64,
  parameter logic [7:0] PREFIX = 8'hA5,
  parameter logic [7:0] ADDR = 8'h3C,
  parameter int TIMEOUT = 48000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH*8-1:0] ch_data,
  input  logic [N_CH-1:0]   ch_valid,
  input  logic [N_CH-1:0]   ch_last,
  output logic [N_CH-1:0]   ch_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic [2:0]        cur_ch
);

  localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  if (N_CH < 1 || N_CH > 8 || MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT < 1) begin : g_bad_param
    $error("rsp_encoder: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_PREFIX,
    S_ADDR,
    S_SRC,
    S_LEN,
    S_DATA,
    S_CRC
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cur_ch_q, cur_ch_d;
  logic [2:0]  rr_ptr_q, rr_ptr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  crc_q, crc_d;
  logic [7:0]  nxt_q, nxt_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;

  logic [7:0]  mem [MAX_LEN];
  logic [7:0]  rd_q;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;

  logic [2:0]  pick_hi, pick_lo, pick;
  logic        hit_hi, hit_lo;
  logic [7:0]  sel_byte;
  logic        sel_valid;
  logic        sel_last;
  logic        acc;
  logic        tx_fire;
  logic        close_frame;

  // Round-robin pick: lowest valid channel above rr_ptr, else lowest valid overall.
  always_comb begin
    pick_hi = '0;
    pick_lo = '0;
    hit_hi  = 1'b0;
    hit_lo  = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (ch_valid[i]) begin
        pick_lo = 3'(i);
        hit_lo  = 1'b1;
        if (3'(i) > rr_ptr_q) begin
          pick_hi = 3'(i);
          hit_hi  = 1'b1;
        end
      end
    end
    pick = hit_hi ? pick_hi : pick_lo;
  end

  always_comb begin
    sel_byte  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (cur_ch_q == 3'(i)) begin
        sel_byte  = ch_data[8*i +: 8];
        sel_valid = ch_valid[i];
        sel_last  = ch_last[i];
      end
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_rdy
    assign ch_ready[gi] = (state_q == S_COLLECT) && (cur_ch_q == 3'(gi)) && (cnt_q < MAX_LEN_B);
  end

  assign acc     = sel_valid && (state_q == S_COLLECT) && (cnt_q < MAX_LEN_B);
  assign tx_fire = tx_valid_q && tx_ready;

  // rd_q always holds mem[nxt_q], so the next data byte is ready on any transfer.
  assign wr_addr = AW'(cnt_q);
  assign rd_addr = (nxt_d < MAX_LEN_B) ? AW'(nxt_d) : '0;

  always_ff @(posedge clk) begin
    if (acc) begin
      mem[wr_addr] <= sel_byte;
    end
    rd_q <= mem[rd_addr];
  end

`ifdef RSP_ENC_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] to_q, to_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_q <= '0;
    end else begin
      to_q <= to_d;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    cur_ch_d    = cur_ch_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    crc_d       = crc_q;
    nxt_d       = nxt_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    close_frame = 1'b0;
`ifdef RSP_ENC_TIMEOUT_EN
    to_d        = to_q;
`endif

    case (state_q)
      S_IDLE: begin
        nxt_d = '0;
        if (hit_lo) begin
          cur_ch_d = pick;
          rr_ptr_d = pick;
          cnt_d    = '0;
          crc_d    = '0;
          state_d  = S_COLLECT;
`ifdef RSP_ENC_TIMEOUT_EN
          to_d     = '0;
`endif
        end
      end

      S_COLLECT: begin
        if (acc) begin
          cnt_d = cnt_q + 8'd1;
          crc_d = crc_q + sel_byte;
          if (sel_last || (cnt_q + 8'd1 == MAX_LEN_B)) begin
            close_frame = 1'b1;
          end
`ifdef RSP_ENC_TIMEOUT_EN
          to_d = '0;
        end else if (to_q == TO_LAST) begin
          // An empty stalled message is abandoned; rr_ptr already moved past it.
          if (cnt_q != 8'd0) begin
            close_frame = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          to_d = to_q + 1'b1;
`endif
        end
        if (close_frame) begin
          state_d    = S_PREFIX;
          tx_valid_d = 1'b1;
          tx_data_d  = PREFIX;
        end
      end

      S_PREFIX: begin
        if (tx_fire) begin
          tx_data_d = ADDR;
          state_d   = S_ADDR;
        end
      end

      S_ADDR: begin
        if (tx_fire) begin
          tx_data_d = {5'b0, cur_ch_q};
          state_d   = S_SRC;
        end
      end

      S_SRC: begin
        if (tx_fire) begin
          tx_data_d = cnt_q;
          state_d   = S_LEN;
        end
      end

      S_LEN: begin
        if (tx_fire) begin
          tx_data_d = rd_q;
          nxt_d     = 8'd1;
          state_d   = S_DATA;
        end
      end

      S_DATA: begin
        if (tx_fire) begin
          if (nxt_q == cnt_q) begin
            tx_data_d = crc_q;
            state_d   = S_CRC;
          end else begin
            tx_data_d = rd_q;
            nxt_d     = nxt_q + 8'd1;
          end
        end
      end

      S_CRC: begin
        if (tx_fire) begin
          tx_valid_d = 1'b0;
          tx_data_d  = '0;
          state_d    = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cur_ch_q   <= '0;
      rr_ptr_q   <= 3'(N_CH - 1);
      cnt_q      <= '0;
      crc_q      <= '0;
      nxt_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_ch_q   <= cur_ch_d;
      rr_ptr_q   <= rr_ptr_d;
      cnt_q      <= cnt_d;
      crc_q      <= crc_d;
      nxt_q      <= nxt_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = (state_q != S_IDLE);
  assign cur_ch   = cur_ch_q;

endmodule

// File: doc/rsp_encoder.md
Name: rsp_encoder

Overview:
- Transmit-side framer for the host byte link. It is the counterpart of the command decoder.
- Collects messages from N_CH on-chip source channels and serialises each one as a frame: PREFIX, ADDR, SRC, LEN, DATA[0..LEN-1], CRC.
- Output is a byte stream (tx_data/tx_valid/tx_ready) that feeds the UART transmitter.
- Round-robin arbitration across channels, store-and-forward through one internal MAX_LEN-byte buffer.

Parameters:
- N_CH, 5, number of source channels (1..8).
- MAX_LEN, 64, maximum data bytes per frame (1..255).
- PREFIX, `PREFIX (defines.v), first frame byte.
- ADDR, `ADDR_AST (defines.v), second frame byte (own address).
- TIMEOUT, 48000, idle-cycle limit for the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- ch_data  in  N_CH*8  byte from channel i at bits [8i+7:8i]
- ch_valid  in  N_CH  channel i has a byte
- ch_last  in  N_CH  byte on channel i ends its message
- ch_ready  out  N_CH  encoder accepts from channel i
- tx_data  out  8  frame byte to UART
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  UART accepts byte
- busy  out  1  state != IDLE
- cur_ch  out  3  channel currently selected

Behaviour:
- Reset (async, rst=0):
  - state=IDLE, tx_valid=0, tx_data=0, ch_ready=0, busy=0, cur_ch=0.
  - cnt=0, crc=0, rr_ptr=N_CH-1 (so channel 0 wins first).
  - Reset mid-frame discards the buffer. No partial frame is ever resumed.
- Transfers: a channel byte moves when ch_valid[i]&ch_ready[i]; an output byte moves when tx_valid&tx_ready.
- Output rule: tx_valid, once high, holds with tx_data stable until tx_ready. It never drops without a transfer.
- States and transitions:
  - IDLE: if any ch_valid, select the first valid channel after rr_ptr, wrapping modulo N_CH. Set cur_ch and rr_ptr to it, clear cnt and crc, go to COLLECT next cycle.
  - COLLECT:
    - ch_ready[cur_ch] = (cnt<MAX_LEN), combinational from registers; all other ch_ready are 0.
    - Each accepted byte goes to buf[cnt], cnt+=1, crc+=byte (8-bit, wraps mod 256).
    - Accepted byte with ch_last=1, or cnt reaching MAX_LEN, goes to SEND_PREFIX.
    - Any bytes after a MAX_LEN cut form a new message in a later arbitration.
  - SEND_PREFIX, SEND_ADDR, SEND_SRC, SEND_LEN: emit PREFIX, ADDR, {5'b0,cur_ch}, cnt in that order. Each state advances on its output transfer.
  - SEND_DATA: emit buf[idx] for idx=0..cnt-1. After the last data byte, go to SEND_CRC.
  - SEND_CRC: emit crc; on transfer go to IDLE.
- Latency: tx_valid rises with PREFIX the cycle after the closing byte is accepted. IDLE costs one cycle between frames.
- LEN is always 1..MAX_LEN; zero-length frames never occur.
- CRC = sum of data bytes mod 256; header bytes are excluded.
- ch_valid or ch_last on non-selected channels is ignored (ch_ready=0). ch_last is meaningful only with ch_valid.
- tx_ready held low stalls the FSM indefinitely. Nothing is dropped; sources back-pressure, since ch_ready=0 outside COLLECT.

Optional Feature:
- Macro RSP_ENC_TIMEOUT_EN.
- Defined: in COLLECT, a counter clears on every accepted byte and increments otherwise. When it hits TIMEOUT-1 with cnt>=1, the frame closes as if ch_last had been seen. With cnt=0, the FSM returns to IDLE with no output and rr_ptr already advanced.
- Undefined: no counter; COLLECT waits forever for ch_last or MAX_LEN.

Test Plan:
- Ch2 sends 0x01,0x02,0x03 (last on 0x03), tx_ready=1 → tx bytes PREFIX, ADDR, 0x02, 0x03, 0x01, 0x02, 0x03, 0x06; PREFIX appears one cycle after 0x03 is accepted.
- Ch0 and ch4 both valid from reset → ch0 frame first, then ch4. With ch0 valid again, ch4 then ch0 alternate (round-robin).
- Ch1 sends 70 bytes 0xFF with last on byte 70, MAX_LEN=64 → frame1 LEN=0x40, CRC=0xC0; frame2 LEN=0x06, CRC=0xFA.
- tx_ready toggles 0/1 randomly during a frame → tx_data stable while tx_valid&!tx_ready, byte sequence identical to the unstalled run.
- rst pulsed low mid-SEND_DATA → tx_valid=0 immediately; next frame starts cleanly with PREFIX and correct CRC.
- With RSP_ENC_TIMEOUT_EN, TIMEOUT=100, ch3 sends 2 bytes 0x10,0x20 then stalls → after 100 idle cycles, frame LEN=0x02, CRC=0x30.
